// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Elastic DMA-to-TPL DAC sample buffer in the link_clk domain, with a prefill start-up gate.
// Optional build macro DAC_FIFO_HOLD_ON_UNF_EN: repeat the last popped word while the buffer is empty in RUN.
module ad_ip_jesd204_tpl_dac_fifo #(
    parameter int DATA_WIDTH    = 128,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = 4,
    parameter int PREFILL_LEVEL = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_CHANNELS-1:0] dac_valid,
    output logic [DATA_WIDTH-1:0]   dac_ddata,
    output logic                    dac_dunf,
    output logic [ADDR_WIDTH:0]     fifo_level,
    output logic [1:0]              dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PREFILL_THR = (ADDR_WIDTH+1)'(PREFILL_LEVEL);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  dunf_q, dunf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic stream_on, strobe, full, empty, is_run;
    logic push, pop, underflow, flush;
    logic [DATA_WIDTH-1:0] head_data;

    assign stream_on = |enable;
    assign strobe    = |dac_valid;
    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign is_run    = (state_q == ST_RUN);

    // Upstream handshake: a beat transfers on a rising edge where s_valid and s_ready are
    // both high; s_ready depends only on state and occupancy, never on s_valid.
    assign s_ready   = (state_q != ST_IDLE) && !full;
    assign push      = s_valid && s_ready;
    assign pop       = strobe && is_run && !empty;
    assign underflow = strobe && is_run && empty;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (stream_on) state_d = ST_PREFILL;
            ST_PREFILL: begin
                if (!stream_on)                 state_d = ST_IDLE;
                else if (level_q >= PREFILL_THR) state_d = ST_RUN;
            end
            ST_RUN:     if (!stream_on) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Any edge that lands in IDLE discards the buffer contents on that same edge.
    assign flush = (state_d == ST_IDLE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dunf_d   = underflow;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dunf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dunf_q   <= dunf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

`ifdef DAC_FIFO_HOLD_ON_UNF_EN
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (pop)   hold_d = head_data;
        if (flush) hold_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end

    always_comb begin
        dac_ddata = '0;
        if (is_run) dac_ddata = empty ? hold_q : head_data;
    end
`else
    always_comb begin
        dac_ddata = '0;
        if (is_run && !empty) dac_ddata = head_data;
    end
`endif

    assign dac_dunf   = dunf_q;
    assign fifo_level = level_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Bench for ad_ip_jesd204_tpl_dac_fifo: directed scenarios plus a random run against a queue-based model.
module tb_ad_ip_jesd204_tpl_dac_fifo;

    localparam int DW      = 128;
    localparam int NC      = 2;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] enable = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [NC-1:0] dac_valid = '0;
    logic [DW-1:0] dac_ddata;
    logic          dac_dunf;
    logic [AW:0]   fifo_level;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = idle, 1 = prefill, 2 = run; buffered beats live in exp_q.
    int            mode = 0;
    logic [DW-1:0] exp_q[$];
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_hold = '0;

    ad_ip_jesd204_tpl_dac_fifo #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .PREFILL_LEVEL(PREFILL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .dac_valid(dac_valid), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
        .fifo_level(fifo_level), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic exp_ready();
        return (mode != 0) && (exp_q.size() < DEPTH);
    endfunction

    function automatic logic [DW-1:0] unf_data();
`ifdef DAC_FIFO_HOLD_ON_UNF_EN
        return m_hold;
`else
        return '0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data();
        if (mode != 2) return '0;
        if (exp_q.size() == 0) return unf_data();
        return exp_q[0];
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT sees at that edge.
    task automatic tick();
        int sz;
        logic strobe, acc;
        @(posedge clk);
        sz = exp_q.size();
        if (reset) begin
            mode = 0;
            exp_q.delete();
            m_unf = 1'b0;
            m_hold = '0;
        end else begin
            strobe = |dac_valid;
            acc = s_valid && exp_ready();
            m_unf = strobe && (mode == 2) && (sz == 0);
            if (strobe && mode == 2 && sz > 0) m_hold = exp_q.pop_front();
            if (acc) exp_q.push_back(s_data);
            if (mode == 0) begin
                if (|enable) mode = 1;
            end else if (enable == '0) mode = 0;
            else if (mode == 1 && sz >= PREFILL) mode = 2;
            if (mode == 0) begin
                exp_q.delete();
                m_hold = '0;
            end
        end
        #1;
    endtask

    task automatic start_stream(input logic [NC-1:0] en);
        reset = 1'b1; s_valid = 1'b0; dac_valid = '0; enable = '0;
        tick();
        reset = 1'b0; enable = en;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = rand_beat(); enable = 2'b11; dac_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
            if (dac_ddata !== '0) begin errors++; $display("FAIL reset_ddata got=%h exp=0", dac_ddata); end
            if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
            if (dac_dunf !== 1'b0) begin errors++; $display("FAIL reset_dunf got=%b exp=0", dac_dunf); end
        end
        reset = 1'b0; s_valid = 1'b0; dac_valid = '0;
        tick();
        checks += 3;
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL reset_to_prefill got=%0d exp=1", dbg_state); end
        if (s_ready !== 1'b1) begin errors++; $display("FAIL prefill_s_ready got=%b exp=1", s_ready); end
        if (fifo_level !== '0) begin errors++; $display("FAIL prefill_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_prefill();
        start_stream(2'b01);
        dac_valid = 2'b01;
        for (int i = 1; i <= PREFILL; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            checks += 3;
            if (fifo_level !== (AW+1)'(i-1)) begin errors++; $display("FAIL prefill_fill got=%0d exp=%0d", fifo_level, i-1); end
            if (dac_ddata !== '0) begin errors++; $display("FAIL prefill_ddata got=%h exp=0", dac_ddata); end
            if (dac_dunf !== 1'b0) begin errors++; $display("FAIL prefill_dunf got=%b exp=0", dac_dunf); end
            tick();
        end
        s_valid = 1'b0;
        checks += 2;
        if (fifo_level !== (AW+1)'(PREFILL)) begin errors++; $display("FAIL prefill_full got=%0d exp=%0d", fifo_level, PREFILL); end
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL prefill_hold got=%0d exp=1", dbg_state); end
        tick();
        checks++;
        if (dbg_state !== 2'd2) begin errors++; $display("FAIL prefill_to_run got=%0d exp=2", dbg_state); end
        for (int k = 1; k <= PREFILL; k++) begin
            checks++;
            if (dac_ddata !== DW'(k)) begin errors++; $display("FAIL run_order got=%h exp=%h", dac_ddata, DW'(k)); end
            tick();
        end
        dac_valid = '0;
        checks += 2;
        if (fifo_level !== '0) begin errors++; $display("FAIL run_drained got=%0d exp=0", fifo_level); end
        if (dac_dunf !== 1'b0) begin errors++; $display("FAIL run_no_unf got=%b exp=0", dac_dunf); end
    endtask

    task automatic test_full_wrap();
        start_stream(2'b11);
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1; s_data = rand_beat();
            tick();
        end
        checks += 2;
        if (fifo_level !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL full_level got=%0d exp=%0d", fifo_level, DEPTH); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        for (int i = 0; i < 2; i++) begin
            s_data = rand_beat();
            tick();
            checks += 2;
            if (fifo_level !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL full_ignore got=%0d exp=%0d", fifo_level, DEPTH); end
            if (dac_ddata !== exp_data()) begin errors++; $display("FAIL full_head got=%h exp=%h", dac_ddata, exp_data()); end
        end
        s_valid = 1'b0; dac_valid = 2'b10;
        tick();
        dac_valid = '0;
        checks += 2;
        if (fifo_level !== (AW+1)'(DEPTH-1)) begin errors++; $display("FAIL one_pop_level got=%0d exp=%0d", fifo_level, DEPTH-1); end
        if (s_ready !== 1'b1) begin errors++; $display("FAIL one_pop_ready got=%b exp=1", s_ready); end
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_data = rand_beat(); dac_valid = 2'b01;
            checks += 2;
            if (dac_ddata !== exp_data()) begin errors++; $display("FAIL wrap_data got=%h exp=%h", dac_ddata, exp_data()); end
            if (fifo_level !== (AW+1)'(DEPTH-1)) begin errors++; $display("FAIL wrap_level got=%0d exp=%0d", fifo_level, DEPTH-1); end
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            checks++;
            if (dac_ddata !== exp_data()) begin errors++; $display("FAIL wrap_drain got=%h exp=%h", dac_ddata, exp_data()); end
            tick();
        end
        dac_valid = '0;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] last;
        start_stream(2'b10);
        for (int i = 0; i < PREFILL; i++) begin
            s_valid = 1'b1; s_data = rand_beat();
            tick();
        end
        s_valid = 1'b0;
        tick();
        dac_valid = 2'b11;
        for (int i = 0; i < PREFILL-1; i++) tick();
        dac_valid = '0;
        checks++;
        if (fifo_level !== (AW+1)'(1)) begin errors++; $display("FAIL unf_level1 got=%0d exp=1", fifo_level); end
        last = exp_q[0];
        dac_valid = 2'b01;
        checks++;
        if (dac_ddata !== last) begin errors++; $display("FAIL unf_last_read got=%h exp=%h", dac_ddata, last); end
        tick();
        checks += 3;
        if (dac_dunf !== 1'b0) begin errors++; $display("FAIL unf_first_ok got=%b exp=0", dac_dunf); end
        if (fifo_level !== '0) begin errors++; $display("FAIL unf_empty got=%0d exp=0", fifo_level); end
        if (dac_ddata !== unf_data()) begin errors++; $display("FAIL unf_ddata got=%h exp=%h", dac_ddata, unf_data()); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 2;
            if (dac_dunf !== 1'b1) begin errors++; $display("FAIL unf_pulse got=%b exp=1", dac_dunf); end
            if (dac_ddata !== unf_data()) begin errors++; $display("FAIL unf_hold got=%h exp=%h", dac_ddata, unf_data()); end
        end
        dac_valid = '0;
        tick();
        checks++;
        if (dac_dunf !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", dac_dunf); end
    endtask

    task automatic test_empty_push();
        logic [DW-1:0] beat;
        beat = rand_beat();
        s_valid = 1'b1; s_data = beat; dac_valid = 2'b01;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ep_ready got=%b exp=1", s_ready); end
        tick();
        s_valid = 1'b0; dac_valid = '0;
        checks += 3;
        if (dac_dunf !== 1'b1) begin errors++; $display("FAIL ep_dunf got=%b exp=1", dac_dunf); end
        if (fifo_level !== (AW+1)'(1)) begin errors++; $display("FAIL ep_level got=%0d exp=1", fifo_level); end
        if (dac_ddata !== beat) begin errors++; $display("FAIL ep_head got=%h exp=%h", dac_ddata, beat); end
        dac_valid = 2'b10;
        tick();
        dac_valid = '0;
        checks += 2;
        if (fifo_level !== '0) begin errors++; $display("FAIL ep_popped got=%0d exp=0", fifo_level); end
        if (dac_dunf !== 1'b0) begin errors++; $display("FAIL ep_no_unf got=%b exp=0", dac_dunf); end
    endtask

    task automatic test_enable_drop();
        start_stream(2'b11);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = DW'(32'hA000 + i);
            tick();
        end
        s_valid = 1'b0;
        checks += 2;
        if (fifo_level !== (AW+1)'(10)) begin errors++; $display("FAIL ed_level got=%0d exp=10", fifo_level); end
        if (dbg_state !== 2'd2) begin errors++; $display("FAIL ed_run got=%0d exp=2", dbg_state); end
        enable = '0;
        tick();
        checks += 4;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL ed_idle got=%0d exp=0", dbg_state); end
        if (fifo_level !== '0) begin errors++; $display("FAIL ed_flush got=%0d exp=0", fifo_level); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ed_ready got=%b exp=0", s_ready); end
        if (dac_ddata !== '0) begin errors++; $display("FAIL ed_ddata got=%h exp=0", dac_ddata); end
        enable = 2'b10;
        tick();
        checks++;
        if (dbg_state !== 2'd1) begin errors++; $display("FAIL ed_reprefill got=%0d exp=1", dbg_state); end
        for (int i = 0; i < PREFILL; i++) begin
            s_valid = 1'b1; s_data = DW'(32'hB000 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        dac_valid = 2'b01;
        for (int i = 0; i < PREFILL; i++) begin
            checks++;
            if (dac_ddata !== DW'(32'hB000 + i)) begin errors++; $display("FAIL ed_new_data got=%h exp=%h", dac_ddata, DW'(32'hB000 + i)); end
            tick();
        end
        dac_valid = '0;
    endtask

    task automatic test_random();
        start_stream(2'b11);
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) enable = NC'($urandom_range(0, 3));
            else if (enable == '0 && $urandom_range(0, 3) == 0) enable = 2'b01;
            s_valid = ($urandom_range(0, 99) < 55);
            s_data = rand_beat();
            dac_valid = ($urandom_range(0, 99) < 50) ? NC'($urandom_range(1, 3)) : '0;
            checks += 4;
            if (s_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, s_ready, exp_ready()); end
            if (fifo_level !== (AW+1)'(exp_q.size())) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, fifo_level, exp_q.size()); end
            if (dac_ddata !== exp_data()) begin errors++; $display("FAIL rnd_ddata cyc=%0d got=%h exp=%h", c, dac_ddata, exp_data()); end
            if (dac_dunf !== m_unf) begin errors++; $display("FAIL rnd_dunf cyc=%0d got=%b exp=%b", c, dac_dunf, m_unf); end
            tick();
        end
        reset = 1'b0; s_valid = 1'b0; dac_valid = '0;
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_full_wrap();
        test_underflow();
        test_empty_push();
        test_enable_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_fifo.md
Name: ad_ip_jesd204_tpl_dac_fifo

Overview:
Elastic sample buffer directly upstream of the JESD204 TPL DAC core, in the link_clk domain. Accepts DMA beats over a valid/ready stream and presents them on dac_ddata. Pops one beat per TPL dac_valid strobe and reports underflow on dac_dunf. Gates start-up with a prefill threshold so the TPL never starts on a near-empty buffer.

Parameters:
DATA_WIDTH, 128, beat width; equals NUM_LANES*8*OCTETS_PER_BEAT of the TPL.
NUM_CHANNELS, 2, width of the enable/dac_valid vectors.
ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16.
PREFILL_LEVEL, 8, occupancy required to leave PREFILL; legal range 1..2**ADDR_WIDTH.

Ports:
clk  input  1  link_clk; all logic on rising edge.
reset  input  1  synchronous, active-high.
enable  input  NUM_CHANNELS  channel enables from TPL; any bit set = stream active.
s_valid  input  1  DMA beat valid.
s_ready  output  1  FIFO can accept a beat.
s_data  input  DATA_WIDTH  DMA beat.
dac_valid  input  NUM_CHANNELS  TPL read strobe; pop when any bit high.
dac_ddata  output  DATA_WIDTH  head beat to TPL.
dac_dunf  output  1  underflow flag, one pulse per underflowed read.
fifo_level  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.

Behaviour:
- Reset values: state=IDLE, level=0, rd/wr pointers=0, s_ready=0, dac_ddata=0, dac_dunf=0, fifo_level=0.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap modulo depth. level is ADDR_WIDTH+1 bits. full = (level == 2**ADDR_WIDTH); empty = (level == 0).
- push = s_valid & s_ready. pop = (|dac_valid) & (state==RUN) & !empty. level updates next cycle by +push-pop; simultaneous push and pop leaves level unchanged.
- s_ready = (state != IDLE) & !full, registered-free (combinational from state/level).
- dac_ddata (combinational from registers, first-word-fall-through): mem[rd_ptr] when state==RUN and !empty; otherwise 0 (see optional feature).
- Underflow: (|dac_valid) & state==RUN & empty -> dac_dunf=1 on the next cycle, for exactly one cycle per offending strobe. Read pointer does not move.
- Empty with push and dac_valid in the same cycle: counts as an underflow. The pushed beat is stored; there is no bypass.
- dac_valid outside RUN: ignored. No pop, no dac_dunf.
- State machine:
  - IDLE: buffer flushed, s_ready=0. Goes to PREFILL when |enable.
  - PREFILL: accepts beats, no pops. Goes to RUN when level >= PREFILL_LEVEL. Goes to IDLE if enable==0.
  - RUN: pops on strobes. Goes to IDLE if enable==0. Underflow does not leave RUN.
- Entering IDLE (enable drop or reset, including mid-stream): pointers and level are cleared on the same clock edge; buffered data is discarded.
- Latency: s_data accepted at edge N is visible on dac_ddata at N+1 at the earliest, when it is the head and state==RUN.

Optional Feature:
DAC_FIFO_HOLD_ON_UNF_EN.
- Defined: an output-hold register captures every popped word. On an underflow, and in RUN while empty, dac_ddata repeats the last popped word. The hold register resets to 0 on reset and on IDLE entry.
- Undefined: dac_ddata = 0 whenever not RUN or empty. No hold register is synthesized.
- dac_dunf behaviour is identical in both builds.

Test Plan:
1. reset=1 for 3 cycles with s_valid=1 and enable=2'b11 -> s_ready=0, dac_ddata=0, fifo_level=0, dac_dunf=0 throughout; PREFILL entered on the first cycle after reset drops.
2. enable=2'b01; push beats 0x1..0x8; dac_valid held high -> no pop until level=8. RUN from the next cycle; dac_ddata then reads 0x1,0x2,... one per cycle in order.
3. Fill to 16 beats in RUN with dac_valid=0 -> s_ready=0 at level 16, further s_valid ignored. One dac_valid pulse -> level 15, s_ready=1. Write pointer wraps correctly across 20 further beats with data intact.
4. RUN, level=1, dac_valid high for 3 cycles, no pushes -> first read returns the beat; the 2nd and 3rd produce dac_dunf pulses one cycle later. dac_ddata=0, or the last beat with DAC_FIFO_HOLD_ON_UNF_EN.
5. Empty in RUN, push and dac_valid in the same cycle -> dac_dunf=1 next cycle and level=1. The next strobe returns the pushed beat.
6. RUN, level=10, enable drops to 0 -> next cycle state=IDLE, level=0, s_ready=0. Re-enable -> PREFILL; old data is never output.
